// File: rtl/mem_wait_responder.sv
// mem_wait_responder: request/ready memory responder with WAIT_STATES cycles of latency.
// Define MEM_PERF_CNT_EN to add the saturating rd_count/wr_count commit counters.
module mem_wait_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [1:0]  state_out
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS = WAIT_STATES[3:0];
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2, ILL = 2'd3} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_we, r_err;
  logic [31:0] r_mem [DEPTH];
  logic        w_accept, w_commit, w_we, w_mis;
  logic [31:0] w_addr, w_wdata;
  logic [AW-1:0] w_idx;
  logic        w_unused;
  assign w_accept = (r_state == IDLE) && req;
  // With no wait states the commit edge is the accept edge, so use live inputs there.
  assign w_commit = (w_accept && WS == 4'd0) || (r_state == WAIT && r_cnt <= 4'd1);
  assign w_addr   = (r_state == IDLE) ? addr  : r_addr;
  assign w_wdata  = (r_state == IDLE) ? wdata : r_wdata;
  assign w_we     = (r_state == IDLE) ? we    : r_we;
  assign w_mis    = |w_addr[1:0];
  assign w_idx    = w_addr[AW+1:2];
  assign w_unused = ^{r_addr[31:AW+2], addr[31:AW+2]};
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_next     = (WS != 4'd0) ? WAIT : DONE;
          w_cnt_next = WS;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        w_next     = (r_cnt <= 4'd1) ? DONE : WAIT;
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_we    <= we;
      end
      if (w_commit) begin
        r_err <= w_mis;
        if (!w_we) r_rdata <= w_mis ? 32'd0 : r_mem[w_idx];
      end
    end
  end
  // Array is not reset; gating on reset drops a commit coinciding with reset assertion.
  always_ff @(posedge clock) begin
    if (reset && w_commit && w_we && !w_mis) r_mem[w_idx] <= w_wdata;
  end
`ifdef MEM_PERF_CNT_EN
  logic [15:0] r_rd_count, r_wr_count;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else if (w_commit && !w_mis) begin
      if (w_we) r_wr_count <= (r_wr_count == 16'hFFFF) ? r_wr_count : r_wr_count + 16'd1;
      else      r_rd_count <= (r_rd_count == 16'hFFFF) ? r_rd_count : r_rd_count + 16'd1;
    end
  end
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif
  assign rdata     = r_rdata;
  assign ready     = (r_state == DONE);
  assign err       = ready && r_err;
  assign busy      = (r_state != IDLE);
  assign state_out = r_state;
endmodule

// File: tb/tb_mem_wait_responder.sv
// tb_mem_wait_responder: directed tests on a WAIT_STATES=2 instance (u0) and a WAIT_STATES=0 instance (u1).
module tb_mem_wait_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [31:0] rdata0, rdata1;
  logic ready0, err0, busy0, ready1, err1, busy1;
  logic [1:0] st0, st1;
`ifdef MEM_PERF_CNT_EN
  logic [15:0] rdc0, wrc0, rdc1, wrc1;
`endif
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  mem_wait_responder #(.DEPTH(256), .WAIT_STATES(2)) u0 (
    .clock(clk), .reset(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0), .state_out(st0)
`ifdef MEM_PERF_CNT_EN
    , .rd_count(rdc0), .wr_count(wrc0)
`endif
  );
  mem_wait_responder #(.DEPTH(256), .WAIT_STATES(0)) u1 (
    .clock(clk), .reset(rst_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ready(ready1), .err(err1), .busy(busy1), .state_out(st1)
`ifdef MEM_PERF_CNT_EN
    , .rd_count(rdc1), .wr_count(wrc1)
`endif
  );
  // Issues one request on u0 (s=0) or u1 (s=1); reports accept-to-ready latency, busy cycles, err and rdata at ready.
  task automatic do_req(input bit s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int bc, output logic e, output logic [31:0] rd);
    logic rdy;
    @(negedge clk);
    if (s) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    lat = 0;
    bc = 0;
    rdy = 1'b0;
    while (!rdy && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin req0 = 1'b0; req1 = 1'b0; end
      if (s ? busy1 : busy0) bc++;
      rdy = s ? ready1 : ready0;
    end
    e  = s ? err1 : err0;
    rd = s ? rdata1 : rdata0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (3) @(negedge clk);
    tests++; if (st0 !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", st0); end
    tests++; if (rdata0 !== 32'd0) begin fails++; $display("FAIL reset_rdata got %h exp 0", rdata0); end
    tests++; if ({ready0, err0, busy0} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {ready0, err0, busy0}); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (st0 !== 2'd0 || busy0 !== 1'b0) begin fails++; $display("FAIL idle_after_reset got st=%0d busy=%b exp 0/0", st0, busy0); end
  endtask
  task automatic test_write;
    int lat, bc; logic e; logic [31:0] rd;
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, bc, e, rd);
    tests++; if (lat !== 3) begin fails++; $display("FAIL write_latency got %0d exp 3", lat); end
    tests++; if (bc !== 3) begin fails++; $display("FAIL write_busy_cycles got %0d exp 3", bc); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL write_err got %b exp 0", e); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL write_keeps_rdata got %h exp 0", rd); end
    do_req(0, 1'b1, 32'h20, 32'h1, lat, bc, e, rd);
    tests++; if (lat !== 3) begin fails++; $display("FAIL write2_latency got %0d exp 3", lat); end
  endtask
  task automatic test_read;
    int lat, bc; logic e; logic [31:0] rd;
    do_req(0, 1'b0, 32'h10, 32'h0, lat, bc, e, rd);
    tests++; if (lat !== 3) begin fails++; $display("FAIL read_latency got %0d exp 3", lat); end
    tests++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin fails++; $display("FAIL read_data got %h err=%b exp deadbeef err=0", rd, e); end
    repeat (2) @(negedge clk);
    tests++; if (rdata0 !== 32'hDEADBEEF || ready0 !== 1'b0) begin fails++; $display("FAIL read_hold got %h rdy=%b exp deadbeef rdy=0", rdata0, ready0); end
    do_req(0, 1'b0, 32'h410, 32'h0, lat, bc, e, rd);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL read_wrap got %h exp deadbeef", rd); end
  endtask
  task automatic test_misaligned;
    int lat, bc; logic e; logic [31:0] rd;
    do_req(0, 1'b0, 32'h13, 32'h0, lat, bc, e, rd);
    tests++; if (e !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL mis_read got err=%b rd=%h exp err=1 rd=0", e, rd); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL mis_latency got %0d exp 3", lat); end
    do_req(0, 1'b1, 32'h12, 32'h12345678, lat, bc, e, rd);
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL mis_write_err got %b exp 1", e); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL mis_write_rdata got %h exp 0", rd); end
    do_req(0, 1'b0, 32'h10, 32'h0, lat, bc, e, rd);
    tests++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin fails++; $display("FAIL mis_write_suppressed got %h err=%b exp deadbeef err=0", rd, e); end
  endtask
  task automatic test_back_to_back;
    int n = 0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready0) n++;
    end
    req0 = 1'b0;
    tests++; if (n !== 3) begin fails++; $display("FAIL b2b_accepts got %0d exp 3", n); end
    tests++; if (rdata0 !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_rdata got %h exp deadbeef", rdata0); end
  endtask
  task automatic test_ignore_in_wait;
    int lat, bc; logic e; logic [31:0] rd;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge clk);
    we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hBAD0BAD0;
    repeat (2) @(negedge clk);
    tests++; if (ready0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 32'hDEADBEEF) begin fails++; $display("FAIL wait_inputs_ignored got rdy=%b err=%b rd=%h exp 1/0/deadbeef", ready0, err0, rdata0); end
    req0 = 1'b0;
    do_req(0, 1'b0, 32'h20, 32'h0, lat, bc, e, rd);
    tests++; if (rd !== 32'h1) begin fails++; $display("FAIL wait_req_not_queued got %h exp 1", rd); end
  endtask
  task automatic test_reset_mid;
    int lat, bc; logic e; logic [31:0] rd;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h55;
    @(negedge clk);
    req0 = 1'b0;
    tests++; if (st0 !== 2'd1) begin fails++; $display("FAIL mid_in_wait got %0d exp 1", st0); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (st0 !== 2'd0 || rdata0 !== 32'd0 || busy0 !== 1'b0) begin fails++; $display("FAIL mid_reset got st=%0d rd=%h busy=%b exp 0/0/0", st0, rdata0, busy0); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 1'b0, 32'h20, 32'h0, lat, bc, e, rd);
    tests++; if (rd !== 32'h1) begin fails++; $display("FAIL mid_write_discarded got %h exp 1", rd); end
  endtask
  task automatic test_zero_wait;
    int lat, bc; logic e; logic [31:0] rd;
    do_req(1, 1'b1, 32'h30, 32'hA5A50001, lat, bc, e, rd);
    tests++; if (lat !== 1 || bc !== 1) begin fails++; $display("FAIL zw_write got lat=%0d busy=%0d exp 1/1", lat, bc); end
    do_req(1, 1'b0, 32'h30, 32'h0, lat, bc, e, rd);
    tests++; if (lat !== 1 || rd !== 32'hA5A50001) begin fails++; $display("FAIL zw_read got lat=%0d rd=%h exp 1/a5a50001", lat, rd); end
    @(negedge clk);
    tests++; if (ready1 !== 1'b0 || st1 !== 2'd0) begin fails++; $display("FAIL zw_pulse got rdy=%b st=%0d exp 0/0", ready1, st1); end
    do_req(1, 1'b0, 32'h31, 32'h0, lat, bc, e, rd);
    tests++; if (e !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL zw_mis got err=%b rd=%h exp 1/0", e, rd); end
  endtask
`ifdef MEM_PERF_CNT_EN
  task automatic test_perf;
    int lat, bc; logic e; logic [31:0] rd;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++; if (rdc1 !== 16'd0 || wrc1 !== 16'd0) begin fails++; $display("FAIL perf_reset got %0d/%0d exp 0/0", rdc1, wrc1); end
    for (int i = 0; i < 3; i++) do_req(1, 1'b0, 32'h30, 32'h0, lat, bc, e, rd);
    do_req(1, 1'b1, 32'h40, 32'h7, lat, bc, e, rd);
    do_req(1, 1'b1, 32'h44, 32'h8, lat, bc, e, rd);
    do_req(1, 1'b0, 32'h33, 32'h0, lat, bc, e, rd);
    tests++; if (rdc1 !== 16'd3 || wrc1 !== 16'd2) begin fails++; $display("FAIL perf_counts got %0d/%0d exp 3/2", rdc1, wrc1); end
    force u1.r_wr_count = 16'hFFFF;
    @(negedge clk);
    release u1.r_wr_count;
    do_req(1, 1'b1, 32'h48, 32'h9, lat, bc, e, rd);
    tests++; if (wrc1 !== 16'hFFFF || rdc1 !== 16'd3) begin fails++; $display("FAIL perf_saturate got %h/%0d exp ffff/3", wrc1, rdc1); end
  endtask
`endif
  initial begin
    test_reset;
    test_write;
    test_read;
    test_misaligned;
    test_back_to_back;
    test_ignore_in_wait;
    test_reset_mid;
    test_zero_wait;
`ifdef MEM_PERF_CNT_EN
    test_perf;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
